insmem_port_arbiter: RTL and testbench

//  Shares the single-port instruction BRAM between the CPU fetch unit and the

---
 rtl/insmem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_insmem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/insmem_port_arbiter.sv
// Single-port instruction BRAM arbiter between CPU fetch and the loader/debug port.
// Optional perf counters are enabled by defining INSMEM_ARB_PERF_EN.
module insmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port (read only)
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  // loader / debug port
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  // BRAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              locked
`ifdef INSMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_lock_cycles
`endif
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic {
    StNormal,
    StLocked
  } state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_wait, w_wait_d;
  logic              r_tag_f, r_tag_l;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_f_hold, r_l_hold;

  logic              w_wait_full;
  logic              w_f_acc, w_l_acc, w_l_rd_acc;
  logic [ADDR_W-1:0] w_f_word, w_l_word;
  logic              w_unused_addr;

  assign w_f_word = f_addr[ADDR_W+1:2];
  assign w_l_word = l_addr[ADDR_W+1:2];
  assign w_unused_addr = ^{f_addr[31:ADDR_W+2], f_addr[1:0], l_addr[31:ADDR_W+2], l_addr[1:0]};

  assign w_wait_full = (r_wait == CntW'(MAX_WAIT));

  // l_lock blocks fetch in either state, so fetch is already held off while
  // NORMAL waits to enter LOCKED and is free again the cycle l_lock drops.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (l_lock) begin
      l_gnt = l_req;
    end else if (f_req && l_req && w_wait_full) begin
      l_gnt = 1'b1;
    end else begin
      f_gnt = f_req;
      l_gnt = l_req && !f_req;
    end
  end

  assign w_f_acc    = f_req && f_gnt;
  assign w_l_acc    = l_req && l_gnt;
  assign w_l_rd_acc = w_l_acc && !l_we;

  always_comb begin
    mem_addr  = r_mem_addr;
    mem_we    = 1'b0;
    mem_wdata = 32'h0;
    if (f_gnt) begin
      mem_addr = w_f_word;
    end else if (l_gnt) begin
      mem_addr  = w_l_word;
      mem_we    = l_we;
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    w_wait_d = r_wait;
    if (!l_req || l_gnt) begin
      w_wait_d = '0;
    end else if (!w_wait_full) begin
      w_wait_d = r_wait + 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StNormal: if (l_lock && !w_f_acc) w_state_d = StLocked;
      StLocked: if (!l_lock) w_state_d = StNormal;
      default:  w_state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StNormal;
      r_wait     <= '0;
      r_tag_f    <= 1'b0;
      r_tag_l    <= 1'b0;
      r_mem_addr <= '0;
      r_f_hold   <= 32'h0;
      r_l_hold   <= 32'h0;
    end else begin
      r_state    <= w_state_d;
      r_wait     <= w_wait_d;
      r_tag_f    <= w_f_acc;
      r_tag_l    <= w_l_rd_acc;
      r_mem_addr <= mem_addr;
      if (r_tag_f) r_f_hold <= mem_rdata;
      if (r_tag_l) r_l_hold <= mem_rdata;
    end
  end

  // Returned word bypasses the hold register so rdata is valid with rvalid.
  assign f_rvalid = r_tag_f;
  assign l_rvalid = r_tag_l;
  assign f_rdata  = r_tag_f ? mem_rdata : r_f_hold;
  assign l_rdata  = r_tag_l ? mem_rdata : r_l_hold;
  assign locked   = (r_state == StLocked);

`ifdef INSMEM_ARB_PERF_EN
  logic [31:0] r_perf_conf, r_perf_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_conf <= 32'h0;
      r_perf_lock <= 32'h0;
    end else begin
      // Both requesting always leaves one side refused.
      if (f_req && l_req) r_perf_conf <= r_perf_conf + 32'd1;
      if (r_state == StLocked) r_perf_lock <= r_perf_lock + 32'd1;
    end
  end

  assign perf_conflicts   = r_perf_conf;
  assign perf_lock_cycles = r_perf_lock;
`endif

endmodule

// File: tb/tb_insmem_port_arbiter.sv
// Self-checking bench for insmem_port_arbiter: directed scenarios, then random traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_insmem_port_arbiter;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, l_req, l_we, l_lock;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, mem_we, locked;
  logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
`ifdef INSMEM_ARB_PERF_EN
  logic [31:0] perf_conflicts, perf_lock_cycles;
`endif

  insmem_port_arbiter #(.ADDR_W(10), .MAX_WAIT(MaxWait)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .locked    (locked)
`ifdef INSMEM_ARB_PERF_EN
    ,
    .perf_conflicts   (perf_conflicts),
    .perf_lock_cycles (perf_lock_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // BRAM: filled with pat() during the first 1024 cycles, then registered read.
  logic [31:0] bram [1024];
  int          init_i = 0;
  always @(posedge clk) begin
    if (init_i < 1024) begin
      bram[init_i] <= pat(init_i);
      init_i       <= init_i + 1;
    end else begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] shadow [1024];
  int          m_wait, m_conf, m_lockc;
  bit          m_locked, m_pf, m_pl;
  logic [31:0] m_df, m_dl, m_hf, m_hl;
  logic [9:0]  m_last;

  task automatic model_reset();
    m_wait = 0; m_locked = 0; m_pf = 0; m_pl = 0;
    m_df = 0; m_dl = 0; m_hf = 0; m_hl = 0; m_last = 0;
    m_conf = 0; m_lockc = 0;
  endtask

  task automatic idle_inputs();
    f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
    f_addr = 0; l_addr = 0; l_wdata = 0;
  endtask

  // Check one cycle against the model, then advance model across the edge.
  task automatic cycle();
    bit ef, el, ewe;
    logic [9:0] ea;
    #2;
    if (l_lock) begin
      ef = 0; el = l_req;
    end else if (f_req && l_req && m_wait >= MaxWait) begin
      ef = 0; el = 1;
    end else begin
      ef = f_req; el = l_req && !f_req;
    end
    ea  = ef ? f_addr[11:2] : (el ? l_addr[11:2] : m_last);
    ewe = el && l_we;
    check("f_gnt", 32'(f_gnt), 32'(ef));
    check("l_gnt", 32'(l_gnt), 32'(el));
    check("mem_addr", 32'(mem_addr), 32'(ea));
    check("mem_we", 32'(mem_we), 32'(ewe));
    if (ewe) check("mem_wdata", mem_wdata, l_wdata);
    check("f_rvalid", 32'(f_rvalid), 32'(m_pf));
    check("f_rdata", f_rdata, m_pf ? m_df : m_hf);
    check("l_rvalid", 32'(l_rvalid), 32'(m_pl));
    check("l_rdata", l_rdata, m_pl ? m_dl : m_hl);
    check("locked", 32'(locked), 32'(m_locked));
    @(posedge clk);
    if (f_req && l_req) m_conf++;
    if (m_locked) m_lockc++;
    if (m_pf) m_hf = m_df;
    if (m_pl) m_hl = m_dl;
    if (ewe) shadow[ea] = l_wdata;
    m_pf = ef;
    m_df = shadow[ea];
    m_pl = el && !l_we;
    m_dl = shadow[ea];
    if (!l_req || el) m_wait = 0;
    else if (m_wait < MaxWait) m_wait++;
    if (m_locked) m_locked = l_lock;
    else m_locked = l_lock && !ef;
    m_last = ea;
    #1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
    repeat (1030) @(posedge clk);
    #1;

    // 1: reset state, then reset in the middle of a fetch read
    check("rst_f_gnt", 32'(f_gnt), 32'd0);
    check("rst_l_gnt", 32'(l_gnt), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_f_rdata", f_rdata, 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    rst_n = 1;
    f_req = 1; f_addr = 32'h14;
    cycle();
    #2 rst_n = 0; f_req = 0;
    model_reset();
    #1;
    check("midrst_f_rvalid", 32'(f_rvalid), 32'd0);
    check("midrst_f_rdata", f_rdata, 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    cycle();

    // 2: plain fetch
    f_req = 1; f_addr = 32'h14;
    #1;
    check("t2_f_gnt", 32'(f_gnt), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'd5);
    cycle();
    f_req = 0;
    #1;
    check("t2_f_rvalid", 32'(f_rvalid), 32'd1);
    check("t2_f_rdata", f_rdata, pat(5));
    cycle();

    // 3: loader starved for exactly MAX_WAIT cycles
    f_req = 1; f_addr = 32'h40;
    l_req = 1; l_we = 0; l_addr = 32'h8;
    for (int i = 0; i < int'(MaxWait); i++) begin
      #1 check("t3_l_refused", 32'(l_gnt), 32'd0);
      cycle();
    end
    #1;
    check("t3_l_gnt", 32'(l_gnt), 32'd1);
    check("t3_f_refused", 32'(f_gnt), 32'd0);
    cycle();
    l_req = 0;
    #1;
    check("t3_l_rvalid", 32'(l_rvalid), 32'd1);
    check("t3_l_rdata", l_rdata, pat(2));
    cycle();
    f_req = 0;
    cycle();
`ifdef INSMEM_ARB_PERF_EN
    check("t3_perf_conflicts", perf_conflicts, 32'(m_conf));
`endif

    // 4: locked program load, then fetch the written word
    l_lock = 1; f_req = 1; f_addr = 32'h6C;
    l_req = 1; l_we = 1; l_addr = 32'h6C; l_wdata = 32'hDEAD_BEEF;
    #1 check("t4_f_blocked", 32'(f_gnt), 32'd0);
    cycle();
    l_req = 0; l_we = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t4_locked", 32'(locked), 32'd1);
      check("t4_f_blocked_lk", 32'(f_gnt), 32'd0);
      cycle();
    end
    l_lock = 0;
    #1 check("t4_f_gnt_unlock", 32'(f_gnt), 32'd1);
    cycle();
    f_req = 0;
    #1 check("t4_f_rdata", f_rdata, 32'hDEAD_BEEF);
    cycle();

    // 5: lock raised while a fetch read is returning
    f_req = 1; f_addr = 32'h20;
    cycle();
    l_lock = 1;
    #1;
    check("t5_f_rvalid", 32'(f_rvalid), 32'd1);
    check("t5_f_rdata", f_rdata, pat(8));
    check("t5_not_locked", 32'(locked), 32'd0);
    cycle();
    #1 check("t5_locked", 32'(locked), 32'd1);
    cycle();
    l_lock = 0; f_req = 0;
    cycle();

    // 6: address wrap
    f_req = 1; f_addr = 32'h1014;
    #1 check("t6_mem_addr", 32'(mem_addr), 32'd5);
    cycle();
    f_req = 0;
    #1 check("t6_f_rdata", f_rdata, pat(5));
    cycle();

    // Random traffic, narrow word range so writes and reads collide
    for (int i = 0; i < 600; i++) begin
      f_req   = ($urandom_range(0, 3) != 0);
      l_req   = $urandom_range(0, 1) == 1;
      l_we    = $urandom_range(0, 1) == 1;
      f_addr  = $urandom & ~32'h0000_0FC0;
      l_addr  = $urandom & ~32'h0000_0FC0;
      l_wdata = $urandom;
      if ($urandom_range(0, 11) == 0) l_lock = ~l_lock;
      cycle();
    end
    idle_inputs();
    cycle();
`ifdef INSMEM_ARB_PERF_EN
    check("perf_conflicts", perf_conflicts, 32'(m_conf));
    check("perf_lock_cycles", perf_lock_cycles, 32'(m_lockc));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
